// File: rtl/execute_memory.sv
// execute_memory: execute stage of the 5-stage MIPS pipeline plus the E->M
// pipeline register. Resolves operand forwarding, runs the ALU, picks the
// destination register and registers everything the M/W stages need.
module execute_memory #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // E-stage control
  input  logic                  RegWriteE,
  input  logic                  MemtoRegE,
  input  logic                  MemWriteE,
  input  logic [2:0]            alu_controlE,
  input  logic                  alu_srcE,
  input  logic                  RegDstE,
  // E-stage data
  input  logic [DATA_WIDTH-1:0] RD1_E,
  input  logic [DATA_WIDTH-1:0] RD2_E,
  input  logic [DATA_WIDTH-1:0] sign_imm_outE,
  input  logic [4:0]            RtE,
  input  logic [4:0]            RdE,
  // Forwarding selects from the hazard unit and the writeback source
  input  logic [1:0]            ForwardAE,
  input  logic [1:0]            ForwardBE,
  input  logic [DATA_WIDTH-1:0] ResultW,
  // Outputs
  output logic [4:0]            WriteRegE,
  output logic                  RegWriteM,
  output logic                  MemtoRegM,
  output logic                  MemWriteM,
  output logic [DATA_WIDTH-1:0] ALUOutM,
  output logic [DATA_WIDTH-1:0] WriteDataM,
  output logic [4:0]            WriteRegM
);

  localparam int DW = DATA_WIDTH;

  // Forwarding source select; 2'b11 is reserved and falls back to the register value.
  typedef enum logic [1:0] {
    FWD_REG  = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10,
    FWD_RSVD = 2'b11
  } fwd_sel_e;

  // ALU operation encodings; every other code produces zero.
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  // Everything that crosses the E->M boundary, kept together so the
  // register, its reset and its next-state stay in one place.
  typedef struct packed {
    logic          reg_write;
    logic          mem_to_reg;
    logic          mem_write;
    logic [DW-1:0] alu_out;
    logic [DW-1:0] write_data;
    logic [4:0]    write_reg;
  } em_bundle_t;

  em_bundle_t    em_d;
  em_bundle_t    em_q;

  logic [DW-1:0] src_a_e;
  logic [DW-1:0] write_data_e;
  logic [DW-1:0] src_b_e;
  logic [DW-1:0] alu_result_e;
  logic          less_than_e;

  // Three-way forwarding mux shared by both operands.
  function automatic logic [DW-1:0] fwd_mux(
    input logic [1:0]    sel,
    input logic [DW-1:0] reg_val,
    input logic [DW-1:0] wb_val,
    input logic [DW-1:0] mem_val
  );
    case (fwd_sel_e'(sel))
      FWD_WB:  return wb_val;
      FWD_MEM: return mem_val;
      default: return reg_val;
    endcase
  endfunction

  // Resolve operands: forwarding first, then the immediate override for SrcB.
  // The M-stage source is the registered value, i.e. the result of the
  // previous instruction, so dependent back-to-back ops chain without stalls.
  always_comb begin
    src_a_e      = fwd_mux(ForwardAE, RD1_E, ResultW, em_q.alu_out);
    write_data_e = fwd_mux(ForwardBE, RD2_E, ResultW, em_q.alu_out);
    // Store data always comes from the forwarded register, never the immediate.
    src_b_e      = alu_srcE ? sign_imm_outE : write_data_e;
  end

  // ALU: all arithmetic wraps modulo 2^DW; SLT is a signed comparison.
  always_comb begin
    // NOTE: every combinational output gets a default before the case, so an
    // unlisted opcode cannot leave it unassigned and infer a latch.
    alu_result_e = '0;
    less_than_e  = $signed(src_a_e) < $signed(src_b_e);
    case (alu_op_e'(alu_controlE))
      ALU_AND: alu_result_e = src_a_e & src_b_e;
      ALU_OR:  alu_result_e = src_a_e | src_b_e;
      ALU_ADD: alu_result_e = src_a_e + src_b_e;
      ALU_SUB: alu_result_e = src_a_e - src_b_e;
      ALU_SLT: alu_result_e = {{(DW-1){1'b0}}, less_than_e};
      default: alu_result_e = '0;
    endcase
  end

  // Destination register select; the hazard unit needs it in the same cycle.
  always_comb begin
    WriteRegE = RegDstE ? RdE : RtE;
  end

  // Next-state of the E->M register: no stall or enable, it loads every cycle.
  // A bubble is just an all-zero E bundle produced upstream.
  always_comb begin
    em_d            = '0;
    em_d.reg_write  = RegWriteE;
    em_d.mem_to_reg = MemtoRegE;
    em_d.mem_write  = MemWriteE;
    em_d.alu_out    = alu_result_e;
    em_d.write_data = write_data_e;
    em_d.write_reg  = WriteRegE;
  end

  // E->M pipeline register; asynchronous clear discards the in-flight instruction.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    if (!rst) begin
      em_q <= '0;
    end else begin
      em_q <= em_d;
    end
  end

  // Register outputs.
  always_comb begin
    RegWriteM  = em_q.reg_write;
    MemtoRegM  = em_q.mem_to_reg;
    MemWriteM  = em_q.mem_write;
    ALUOutM    = em_q.alu_out;
    WriteDataM = em_q.write_data;
    WriteRegM  = em_q.write_reg;
  end

endmodule

// File: tb/tb_execute_memory.sv
// Testbench for execute_memory: a table of directed vectors with hand-derived
// expectations, hand-written reset sequences, then randomized traffic checked
// against an arithmetic reference model of the execute stage.
module tb_execute_memory;

  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          RegWriteE, MemtoRegE, MemWriteE;
  logic [2:0]    alu_controlE;
  logic          alu_srcE, RegDstE;
  logic [DW-1:0] RD1_E, RD2_E, sign_imm_outE, ResultW;
  logic [4:0]    RtE, RdE;
  logic [1:0]    ForwardAE, ForwardBE;
  logic [4:0]    WriteRegE;
  logic          RegWriteM, MemtoRegM, MemWriteM;
  logic [DW-1:0] ALUOutM, WriteDataM;
  logic [4:0]    WriteRegM;

  int checks   = 0;
  int failures = 0;

  execute_memory #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .alu_controlE(alu_controlE), .alu_srcE(alu_srcE), .RegDstE(RegDstE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .sign_imm_outE(sign_imm_outE),
    .RtE(RtE), .RdE(RdE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ResultW(ResultW), .WriteRegE(WriteRegE),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the run is a fixed number of cycles, this only guards a hang.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (actual=timeout required=finish)");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
    end
  endtask

  // One E-stage input bundle plus the expected values it produces.
  typedef struct {
    logic          rw, m2r, mw;
    logic [2:0]    ctl;
    logic          src, rdst;
    logic [DW-1:0] rd1, rd2, imm, resw;
    logic [4:0]    rt, rd;
    logic [1:0]    fa, fb;
    logic [4:0]    x_wre;
    logic          x_rw, x_m2r, x_mw;
    logic [DW-1:0] x_alu, x_wd;
    logic [4:0]    x_wrm;
  } vec_t;

  vec_t vecs[$];

  task automatic drive(input logic rw, m2r, mw, input logic [2:0] ctl, input logic src, rdst,
                       input logic [DW-1:0] rd1, rd2, imm, resw, input logic [4:0] rt, rd,
                       input logic [1:0] fa, fb);
    RegWriteE = rw; MemtoRegE = m2r; MemWriteE = mw; alu_controlE = ctl;
    alu_srcE = src; RegDstE = rdst; RD1_E = rd1; RD2_E = rd2; sign_imm_outE = imm;
    ResultW = resw; RtE = rt; RdE = rd; ForwardAE = fa; ForwardBE = fb;
  endtask

  task automatic check_m(input string tag, input logic rw, m2r, mw,
                         input logic [DW-1:0] alu, wd, input logic [4:0] wr);
    check({tag, ".RegWriteM"},  DW'(RegWriteM),  DW'(rw));
    check({tag, ".MemtoRegM"},  DW'(MemtoRegM),  DW'(m2r));
    check({tag, ".MemWriteM"},  DW'(MemWriteM),  DW'(mw));
    check({tag, ".ALUOutM"},    ALUOutM,         alu);
    check({tag, ".WriteDataM"}, WriteDataM,      wd);
    check({tag, ".WriteRegM"},  DW'(WriteRegM),  DW'(wr));
  endtask

  // Reference model of one execute step, written from the operation rules.
  function automatic logic [DW-1:0] ref_pick(input logic [1:0] sel, input logic [DW-1:0] r,
                                             input logic [DW-1:0] w, input logic [DW-1:0] m);
    if (sel == 2'd1) return w;
    if (sel == 2'd2) return m;
    return r;
  endfunction

  function automatic logic [DW-1:0] ref_alu(input logic [2:0] ctl, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (ctl)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return DW'(a + b);
      3'd6: return DW'(a - b);
      3'd7: return (sa < sb) ? DW'(1) : DW'(0);
      default: return '0;
    endcase
  endfunction

  logic [DW-1:0] model_alu_m;  // model's view of ALUOutM

  initial begin
    // rw m2r mw ctl src rdst rd1 rd2 imm resw rt rd fa fb | wre rw m2r mw alu wd wrm
    vecs.push_back('{1,0,0,3'b010,0,1,32'd5,32'd7,32'd0,32'd0,5'd9,5'd3,2'b00,2'b00, 5'd3,1,0,0,32'd12,32'd7,5'd3});
    vecs.push_back('{1,0,0,3'b010,1,0,32'd10,32'h20,32'hFFFFFFFC,32'd0,5'd5,5'd6,2'b00,2'b00, 5'd5,1,0,0,32'd6,32'h20,5'd5});
    vecs.push_back('{1,0,0,3'b111,0,1,32'hFFFFFFFF,32'd1,32'd0,32'd0,5'd1,5'd2,2'b00,2'b00, 5'd2,1,0,0,32'd1,32'd1,5'd2});
    vecs.push_back('{1,0,0,3'b111,0,1,32'd1,32'hFFFFFFFF,32'd0,32'd0,5'd1,5'd4,2'b00,2'b00, 5'd4,1,0,0,32'd0,32'hFFFFFFFF,5'd4});
    vecs.push_back('{1,0,0,3'b010,0,1,32'd1,32'd2,32'd0,32'd0,5'd0,5'd8,2'b00,2'b00, 5'd8,1,0,0,32'd3,32'd2,5'd8});
    vecs.push_back('{1,0,0,3'b010,0,1,32'd99,32'd4,32'd0,32'd0,5'd0,5'd9,2'b10,2'b00, 5'd9,1,0,0,32'd7,32'd4,5'd9});
    vecs.push_back('{0,0,1,3'b010,0,0,32'd1,32'd2,32'd0,32'h55,5'd7,5'd0,2'b00,2'b01, 5'd7,0,0,1,32'h56,32'h55,5'd7});
    vecs.push_back('{1,1,0,3'b011,0,1,32'd5,32'd6,32'd0,32'h55,5'd0,5'd10,2'b00,2'b00, 5'd10,1,1,0,32'd0,32'd6,5'd10});
    vecs.push_back('{1,0,0,3'b110,0,1,32'd8,32'd3,32'd0,32'h55,5'd0,5'd11,2'b11,2'b11, 5'd11,1,0,0,32'd5,32'd3,5'd11});
    vecs.push_back('{1,0,0,3'b000,0,1,32'hF0F0,32'h0FF0,32'd0,32'd0,5'd0,5'd12,2'b00,2'b00, 5'd12,1,0,0,32'h00F0,32'h0FF0,5'd12});
    vecs.push_back('{1,0,0,3'b001,0,1,32'hF000,32'h000F,32'd0,32'd0,5'd0,5'd13,2'b00,2'b00, 5'd13,1,0,0,32'hF00F,32'h000F,5'd13});
    vecs.push_back('{1,0,0,3'b110,0,1,32'd3,32'd5,32'd0,32'd0,5'd0,5'd14,2'b00,2'b00, 5'd14,1,0,0,32'hFFFFFFFE,32'd5,5'd14});
    vecs.push_back('{0,0,0,3'b000,0,0,32'd0,32'd0,32'd0,32'd0,5'd0,5'd0,2'b00,2'b00, 5'd0,0,0,0,32'd0,32'd0,5'd0});
    vecs.push_back('{1,0,0,3'b010,0,1,32'd77,32'd1,32'd0,32'd0,5'd0,5'd15,2'b10,2'b00, 5'd15,1,0,0,32'd1,32'd1,5'd15});
    vecs.push_back('{1,0,0,3'b001,0,0,32'd4,32'd50,32'd0,32'd0,5'd16,5'd17,2'b00,2'b10, 5'd16,1,0,0,32'd5,32'd1,5'd16});
    vecs.push_back('{0,0,1,3'b010,1,0,32'd2,32'd9,32'h10,32'h33,5'd18,5'd19,2'b00,2'b01, 5'd18,0,0,1,32'h12,32'h33,5'd18});

    // Reset state: asserted from time 0, outputs cleared without a clock edge.
    rst = 1'b0;
    drive(1,1,1,3'b010,0,1,32'd1,32'd1,32'd0,32'd0,5'd1,5'd1,2'b00,2'b00);
    #1;
    check_m("reset_initial", 0,0,0,32'd0,32'd0,5'd0);
    @(posedge clk); #1;
    check_m("reset_held", 0,0,0,32'd0,32'd0,5'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed table, applied back-to-back so forwarding chains are exercised.
    foreach (vecs[i]) begin
      vec_t v;
      string tag;
      v = vecs[i];
      tag = $sformatf("vec%0d", i);
      drive(v.rw, v.m2r, v.mw, v.ctl, v.src, v.rdst, v.rd1, v.rd2, v.imm, v.resw,
            v.rt, v.rd, v.fa, v.fb);
      #1;
      check({tag, ".WriteRegE"}, DW'(WriteRegE), DW'(v.x_wre));
      @(posedge clk); #1;
      check_m(tag, v.x_rw, v.x_m2r, v.x_mw, v.x_alu, v.x_wd, v.x_wrm);
    end

    // Mid-cycle reset with non-zero outputs: clear immediately, hold until release.
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_m("reset_midcycle", 0,0,0,32'd0,32'd0,5'd0);
    drive(1,1,1,3'b010,0,1,32'd20,32'd30,32'd0,32'd0,5'd2,5'd21,2'b00,2'b00);
    @(posedge clk); #1;
    check_m("reset_hold", 0,0,0,32'd0,32'd0,5'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_m("reset_release", 1,1,1,32'd50,32'd30,5'd21);
    model_alu_m = 32'd50;

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      logic          rw, m2r, mw, src, rdst;
      logic [2:0]    ctl;
      logic [DW-1:0] rd1, rd2, imm, resw, a, wd, b, x_alu;
      logic [4:0]    rt, rd, x_wr;
      logic [1:0]    fa, fb;
      rw = 1'($urandom); m2r = 1'($urandom); mw = 1'($urandom);
      src = 1'($urandom); rdst = 1'($urandom); ctl = 3'($urandom);
      rd1 = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 8)) : DW'($urandom);
      rd2 = ($urandom_range(0, 3) == 0) ? -DW'($urandom_range(0, 8)) : DW'($urandom);
      imm = DW'($signed(16'($urandom)));
      resw = DW'($urandom); rt = 5'($urandom); rd = 5'($urandom);
      fa = 2'($urandom); fb = 2'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        {rw, m2r, mw, src, rdst, ctl, rd1, rd2, imm, rt, rd, fa, fb} = '0;
      end
      a     = ref_pick(fa, rd1, resw, model_alu_m);
      wd    = ref_pick(fb, rd2, resw, model_alu_m);
      b     = src ? imm : wd;
      x_alu = ref_alu(ctl, a, b);
      x_wr  = rdst ? rd : rt;
      drive(rw, m2r, mw, ctl, src, rdst, rd1, rd2, imm, resw, rt, rd, fa, fb);
      #1;
      if (WriteRegE !== x_wr) check("rand.WriteRegE", DW'(WriteRegE), DW'(x_wr));
      @(posedge clk); #1;
      check_m($sformatf("rand%0d", n), rw, m2r, mw, x_alu, wd, x_wr);
      model_alu_m = x_alu;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
